// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared Wishbone widths, arbiter state type and default watchdog limit.
package wb_arb_pkg;
  localparam int WB_AW = 64;
  localparam int WB_DW = 64;
  localparam int WB_SW = 8;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/wb_rr_pick.sv
// rtl/wb_rr_pick.sv - combinational round-robin picker: first requester scanning up from last+1, wrapping.
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int   k;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(last) + i) % N;
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        idx    = IW'(k);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - per-cycle round-robin Wishbone master arbiter.
// Optional stalled-slave watchdog enabled by WB_ARB_WATCHDOG_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [WB_AW*NUM_MASTERS-1:0] m_adr_i,
  input  logic [WB_DW*NUM_MASTERS-1:0] m_dat_i,
  input  logic [WB_SW*NUM_MASTERS-1:0] m_sel_i,
  output logic [WB_DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic [NUM_MASTERS-1:0]       gnt_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [WB_AW-1:0]             s_adr_o,
  output logic [WB_DW-1:0]             s_dat_o,
  output logic [WB_SW-1:0]             s_sel_o,
  input  logic [WB_DW-1:0]             s_dat_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IW-1:0]          last_q;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   any_req;
  logic                   owner_cyc;
  logic                   active;
  logic                   stb_raw;
  logic                   stb_out;
  logic                   wd_fire;

  wb_rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req  (m_cyc_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign any_req   = |m_cyc_i;
  assign owner_cyc = |(m_cyc_i & gnt_q);
  // last_q doubles as the owner index while OWNED
  assign active    = (state_q == OWNED) && !wb_rst_i;
  assign stb_raw   = active && m_stb_i[last_q];
  assign stb_out   = stb_raw && !wd_fire;
  assign gnt_o     = gnt_q;
  assign m_dat_o   = s_dat_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        gnt_q  <= pick_gnt;
        last_q <= pick_idx;
      end else if (state_d == IDLE) begin
        gnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = OWNED;
      OWNED:   if (!owner_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (active) begin
      s_cyc_o         = m_cyc_i[last_q];
      s_stb_o         = stb_out;
      s_we_o          = m_we_i[last_q];
      s_adr_o         = m_adr_i[int'(last_q)*WB_AW +: WB_AW];
      s_dat_o         = m_dat_i[int'(last_q)*WB_DW +: WB_DW];
      s_sel_o         = m_sel_i[int'(last_q)*WB_SW +: WB_SW];
      // an ack without a live strobe is stale and must not reach the master
      m_ack_o[last_q] = s_ack_i && stb_out;
      m_err_o[last_q] = s_err_i || wd_fire;
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_q;

  assign wd_fire = stb_raw && (wd_cnt_q == CW'(TIMEOUT));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !stb_raw || wd_fire || s_ack_i || s_err_i) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT);
  assign wd_fire        = 1'b0;
`endif

endmodule
